// File: rtl/encoder_prior_4to2.sv
// encoder_prior_4to2: registered 4-to-2 priority encoder.
// The highest-numbered set bit of d wins and its index is reported on y;
// valid flags that any request bit was set at capture.
// Optional feature macro: ENCODER_PRIOR_4TO2_MULTI_EN adds the registered
// output multi, set when two or more request bits were present at capture.
// Outputs load on a rising edge with en=1, hold with en=0, and clear on a
// rising edge with rst_n=0 (synchronous, reset wins over capture).
module encoder_prior_4to2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] d,
   output logic [1:0] y,
   output logic       valid
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
   ,
   output logic       multi
`endif
);

   // Index of the highest set bit; an all-zero vector encodes as 00 and is
   // distinguished from "bit 0 only" by the valid flag.
   function automatic logic [1:0] prio_code(input logic [3:0] v);
      logic [1:0] code;
      casez (v)
         4'b1???: code = 2'b11;
         4'b01??: code = 2'b10;
         4'b001?: code = 2'b01;
         4'b0001: code = 2'b00;
         default: code = 2'b00;
      endcase
      return code;
   endfunction

   // True when any request bit is set.
   function automatic logic any_set(input logic [3:0] v);
      return (v != 4'b0000);
   endfunction

`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
   // True when two or more request bits are set: clearing the lowest set
   // bit leaves something behind only if another bit was also set.
   function automatic logic two_or_more(input logic [3:0] v);
      return ((v & (v - 4'b0001)) != 4'b0000);
   endfunction
`endif

   logic [1:0] y_next_s;
   logic       valid_next_s;
   logic [1:0] y_r;
   logic       valid_r;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
   logic       multi_next_s;
   logic       multi_r;
`endif

   // Combinational encode of the current request vector, captured below.
   always_comb begin
      y_next_s     = 2'b00;
      valid_next_s = 1'b0;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
      multi_next_s = 1'b0;
`endif
      if (any_set(d)) begin
         y_next_s     = prio_code(d);
         valid_next_s = 1'b1;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
         multi_next_s = two_or_more(d);
`endif
      end else begin
         y_next_s     = 2'b00;
         valid_next_s = 1'b0;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
         multi_next_s = 1'b0;
`endif
      end
   end

   // Output registers: synchronous clear, capture on en, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_r     <= 2'b00;
         valid_r <= 1'b0;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
         multi_r <= 1'b0;
`endif
      end else if (en) begin
         y_r     <= y_next_s;
         valid_r <= valid_next_s;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
         multi_r <= multi_next_s;
`endif
      end else begin
         y_r     <= y_r;
         valid_r <= valid_r;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
         multi_r <= multi_r;
`endif
      end
   end

   assign y     = y_r;
   assign valid = valid_r;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
   assign multi = multi_r;
`endif

endmodule

// File: tb/tb_encoder_prior_4to2.sv
// Self-checking bench for encoder_prior_4to2.
// A behavioural model (highest-set-bit search, population count) tracks the
// expected registered outputs; a compare process checks every falling edge.
// Directed steps add literal expectations for the listed scenarios.
module tb_encoder_prior_4to2;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] d;
   logic [1:0] y;
   logic       valid;
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
   logic       multi;
`endif

   int checks = 0;
   int errors = 0;

   encoder_prior_4to2 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (d),
      .y     (y),
      .valid (valid)
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
      ,
      .multi (multi)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic logic [1:0] model_y(input logic [3:0] v);
      int hi;
      hi = 0;
      for (int i = 0; i < 4; i++) if (v[i]) hi = i;
      return 2'(hi);
   endfunction

   function automatic logic model_valid(input logic [3:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) n += int'(v[i]);
      return (n > 0);
   endfunction

   function automatic logic model_multi(input logic [3:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) n += int'(v[i]);
      return (n >= 2);
   endfunction

   logic [1:0] m_y;
   logic       m_valid;
   logic       m_multi;
   logic       armed = 1'b0;

   // Model registers follow the sampled controls at each rising edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_y     <= 2'b00;
         m_valid <= 1'b0;
         m_multi <= 1'b0;
         armed   <= 1'b1;
      end else if (en) begin
         m_y     <= model_y(d);
         m_valid <= model_valid(d);
         m_multi <= model_multi(d);
      end
   end

   // Compare DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (armed) begin
         checks++;
         if (y !== m_y) begin
            errors++;
            $display("FAIL cmp_y t=%0t actual=%b required=%b", $time, y, m_y);
         end
         checks++;
         if (valid !== m_valid) begin
            errors++;
            $display("FAIL cmp_valid t=%0t actual=%b required=%b", $time, valid, m_valid);
         end
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
         checks++;
         if (multi !== m_multi) begin
            errors++;
            $display("FAIL cmp_multi t=%0t actual=%b required=%b", $time, multi, m_multi);
         end
`endif
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
      end
   endtask

   // Drive inputs, let one rising edge capture them, return just after it.
   task automatic apply(input logic r, input logic e, input logic [3:0] v);
      rst_n = r;
      en    = e;
      d     = v;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [1:0] ey, input logic ev, input logic em);
      chk({name, "_y"}, y, ey);
      chk({name, "_valid"}, {1'b0, valid}, {1'b0, ev});
`ifdef ENCODER_PRIOR_4TO2_MULTI_EN
      chk({name, "_multi"}, {1'b0, multi}, {1'b0, em});
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      d     = 4'b0000;

      // Pin the model with hand-computed values.
      chk("model_0110", model_y(4'b0110), 2'b10);
      chk("model_0001", model_y(4'b0001), 2'b00);
      chk("model_v0000", {1'b0, model_valid(4'b0000)}, 2'b00);
      chk("model_m0011", {1'b0, model_multi(4'b0011)}, 2'b01);
      chk("model_m0100", {1'b0, model_multi(4'b0100)}, 2'b00);

      @(posedge clk);
      #1;
      // Reset held with a pending request: outputs stay clear.
      apply(1'b0, 1'b1, 4'b1000); expect_out("rst0", 2'b00, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 4'b1000); expect_out("rst1", 2'b00, 1'b0, 1'b0);
      apply(1'b1, 1'b1, 4'b1000); expect_out("rst_rel", 2'b11, 1'b1, 1'b0);

      // One-hot sweep.
      apply(1'b1, 1'b1, 4'b0001); expect_out("oh0", 2'b00, 1'b1, 1'b0);
      apply(1'b1, 1'b1, 4'b0010); expect_out("oh1", 2'b01, 1'b1, 1'b0);
      apply(1'b1, 1'b1, 4'b0100); expect_out("oh2", 2'b10, 1'b1, 1'b0);
      apply(1'b1, 1'b1, 4'b1000); expect_out("oh3", 2'b11, 1'b1, 1'b0);

      // Multi-bit priority.
      apply(1'b1, 1'b1, 4'b0011); expect_out("mb0011", 2'b01, 1'b1, 1'b1);
      apply(1'b1, 1'b1, 4'b1100); expect_out("mb1100", 2'b11, 1'b1, 1'b1);
      apply(1'b1, 1'b1, 4'b0110); expect_out("mb0110", 2'b10, 1'b1, 1'b1);
      apply(1'b1, 1'b1, 4'b1111); expect_out("mb1111", 2'b11, 1'b1, 1'b1);

      // Empty input.
      apply(1'b1, 1'b1, 4'b0000); expect_out("empty", 2'b00, 1'b0, 1'b0);

      // Mid-stream reset.
      apply(1'b1, 1'b1, 4'b1010); expect_out("pre_rst", 2'b11, 1'b1, 1'b1);
      apply(1'b0, 1'b1, 4'b1010); expect_out("mid_rst", 2'b00, 1'b0, 1'b0);

      // Enable hold.
      apply(1'b1, 1'b1, 4'b0100); expect_out("cap", 2'b10, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         apply(1'b1, 1'b0, 4'b0001); expect_out("hold", 2'b10, 1'b1, 1'b0);
      end
      apply(1'b1, 1'b1, 4'b0001); expect_out("en_rise", 2'b00, 1'b1, 1'b0);

      // Latency: a mid-cycle change of d must not reach y before the edge.
      apply(1'b1, 1'b1, 4'b1000); expect_out("lat_a", 2'b11, 1'b1, 1'b0);
      d = 4'b0010;
      #3;
      expect_out("lat_mid", 2'b11, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      expect_out("lat_b", 2'b01, 1'b1, 1'b0);

      // Randomized traffic, checked by the compare process.
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 15)));
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
